// File: rtl/stage_id.sv
// stage_id: RV32I decode/issue stage feeding the execute-stage operand bundle.
//
// Accepts fetched instructions over a valid/ready handshake, reads the
// register file combinationally, blocks issue on RAW/WAW hazards tracked by
// a busy scoreboard, and holds the decoded bundle in an output register with
// its own valid/ready handshake. Unsupported opcodes are consumed and
// reported through a one-cycle illegal pulse.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_pc/in_instr   fetch handshake and payload
//   rs1_addr/rs2_addr             register file read addresses (from in_instr)
//   rs1_data/rs2_data             register file read data (same cycle)
//   wb_valid/wb_rd/wb_data        writeback strobe clearing scoreboard bits
//   flush                         redirect; kills the output register
//   out_valid/out_ready           EX handshake
//   out_pc/out_rd/out_rd_valid/out_a/out_b/out_offset/out_unit/out_op
//                                 EX operand bundle (unit: 0=ALU, 1=BRU)
//   illegal/illegal_pc            dropped-instruction pulse and its pc
//
// Build option: define STAGE_ID_WB_BYPASS_EN to forward wb_data into the
// sources and issue in the same cycle as the matching writeback.

module stage_id #(
    parameter int unsigned Width   = 32,
    parameter int unsigned NumRegs = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_pc,
    input  logic [31:0]      in_instr,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [Width-1:0] rs1_data,
    input  logic [Width-1:0] rs2_data,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [Width-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_pc,
    output logic [4:0]       out_rd,
    output logic             out_rd_valid,
    output logic [Width-1:0] out_a,
    output logic [Width-1:0] out_b,
    output logic [Width-1:0] out_offset,
    output logic [1:0]       out_unit,
    output logic [3:0]       out_op,
    output logic             illegal,
    output logic [Width-1:0] illegal_pc
);

    typedef enum logic [1:0] {
        UnitAlu = 2'd0,
        UnitBru = 2'd1
    } unit_e;

    typedef enum logic [6:0] {
        OpcOpImm  = 7'b0010011,
        OpcOp     = 7'b0110011,
        OpcLui    = 7'b0110111,
        OpcAuipc  = 7'b0010111,
        OpcJal    = 7'b1101111,
        OpcJalr   = 7'b1100111,
        OpcBranch = 7'b1100011
    } opcode_e;

    typedef struct packed {
        logic [Width-1:0] pc;
        logic [4:0]       rd;
        logic             rd_valid;
        logic [Width-1:0] a;
        logic [Width-1:0] b;
        logic [Width-1:0] offset;
        unit_e            unit;
        logic [3:0]       op;
    } payload_t;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic       alt;
    logic [31:0] imm_i32, imm_u32, imm_b32, imm_j32;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];
    assign alt      = in_instr[30];
    assign rs1_addr = rs1;
    assign rs2_addr = rs2;

    assign imm_i32 = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u32 = {in_instr[31:12], 12'b0};
    assign imm_b32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};

    // Source operands; x0 always reads zero
    logic             wb_hit1, wb_hit2;
    logic [Width-1:0] src1, src2;

`ifdef STAGE_ID_WB_BYPASS_EN
    assign wb_hit1 = wb_valid & (wb_rd == rs1) & (rs1 != 5'd0);
    assign wb_hit2 = wb_valid & (wb_rd == rs2) & (rs2 != 5'd0);
    assign src1    = (rs1 == 5'd0) ? '0 : (wb_hit1 ? wb_data : rs1_data);
    assign src2    = (rs2 == 5'd0) ? '0 : (wb_hit2 ? wb_data : rs2_data);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign wb_hit1 = 1'b0;
    assign wb_hit2 = 1'b0;
    assign src1    = (rs1 == 5'd0) ? '0 : rs1_data;
    assign src2    = (rs2 == 5'd0) ? '0 : rs2_data;
`endif

    // State
    payload_t           pay_q, pay_d;
    logic               out_valid_q, out_valid_d;
    logic [NumRegs-1:0] busy_q, busy_d;
    logic               illegal_q, illegal_d;
    logic [Width-1:0]   illegal_pc_q, illegal_pc_d;

    // Decode
    payload_t dec;
    logic     legal, use1, use2, writes;

    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        use1   = 1'b0;
        use2   = 1'b0;
        writes = 1'b0;
        dec.pc = in_pc;
        case (opcode)
            OpcOpImm: begin
                legal  = 1'b1;
                use1   = 1'b1;
                writes = 1'b1;
                dec.op = {alt & (funct3 == 3'b101), funct3};
                dec.a  = src1;
                dec.b  = Width'($signed(imm_i32));
            end
            OpcOp: begin
                legal  = 1'b1;
                use1   = 1'b1;
                use2   = 1'b1;
                writes = 1'b1;
                dec.op = {alt & ((funct3 == 3'b000) | (funct3 == 3'b101)), funct3};
                dec.a  = src1;
                dec.b  = src2;
            end
            OpcLui: begin
                legal  = 1'b1;
                writes = 1'b1;
                dec.b  = Width'($signed(imm_u32));
            end
            OpcAuipc: begin
                legal  = 1'b1;
                writes = 1'b1;
                dec.a  = in_pc;
                dec.b  = Width'($signed(imm_u32));
            end
            OpcJal: begin
                legal    = 1'b1;
                writes   = 1'b1;
                dec.unit = UnitBru;
                dec.a    = in_pc;
                dec.b    = Width'($signed(imm_j32));
            end
            OpcJalr: begin
                legal    = 1'b1;
                use1     = 1'b1;
                writes   = 1'b1;
                dec.unit = UnitBru;
                dec.a    = src1;
                dec.b    = Width'($signed(imm_i32));
            end
            OpcBranch: begin
                // funct3 010/011 are not defined branch compares
                legal      = (funct3[2:1] != 2'b01);
                use1       = 1'b1;
                use2       = 1'b1;
                dec.unit   = UnitBru;
                dec.op     = {1'b1, funct3};
                dec.a      = src1;
                dec.b      = src2;
                dec.offset = Width'($signed(imm_b32));
            end
            default: ;
        endcase
        dec.rd       = writes ? rd : 5'd0;
        dec.rd_valid = writes & (rd != 5'd0);
    end

    // Hazards: a source is blocked by an outstanding write in the scoreboard
    // or by the bundle still waiting in the output register.
    logic pend1, pend2, pend_rd, raw1, raw2, waw, hazard;
    logic in_fire, out_fire;

    assign pend1   = out_valid_q & pay_q.rd_valid & (pay_q.rd == rs1);
    assign pend2   = out_valid_q & pay_q.rd_valid & (pay_q.rd == rs2);
    assign pend_rd = out_valid_q & pay_q.rd_valid & (pay_q.rd == rd);
    assign raw1    = use1 & (rs1 != 5'd0) & ((busy_q[rs1] & ~wb_hit1) | pend1);
    assign raw2    = use2 & (rs2 != 5'd0) & ((busy_q[rs2] & ~wb_hit2) | pend2);
    assign waw     = dec.rd_valid & (busy_q[rd] | pend_rd);
    assign hazard  = legal & (raw1 | raw2 | waw);

    assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        pay_d        = pay_q;
        out_valid_d  = out_valid_q;
        illegal_d    = in_fire & ~legal;
        illegal_pc_d = (in_fire & ~legal) ? in_pc : illegal_pc_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_fire & legal) begin
            pay_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Set is applied after clear so an issue to r wins over a writeback to r.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NumRegs; r++) begin
            if (wb_valid && (wb_rd == 5'(r))) busy_d[r] = 1'b0;
            if (out_fire && pay_q.rd_valid && (pay_q.rd == 5'(r))) busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pay_q        <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= '0;
            illegal_q    <= 1'b0;
            illegal_pc_q <= '0;
        end else begin
            pay_q        <= pay_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            illegal_q    <= illegal_d;
            illegal_pc_q <= illegal_pc_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = pay_q.pc;
    assign out_rd       = pay_q.rd;
    assign out_rd_valid = pay_q.rd_valid;
    assign out_a        = pay_q.a;
    assign out_b        = pay_q.b;
    assign out_offset   = pay_q.offset;
    assign out_unit     = pay_q.unit;
    assign out_op       = pay_q.op;
    assign illegal      = illegal_q;
    assign illegal_pc   = illegal_pc_q;

endmodule

// File: tb/tb_stage_id.sv
// Directed self-checking bench for stage_id. The register file model returns
// 0x1000+index, and 0xDEADBEEF for x0 so that x0 zeroing is visible.
// Honours STAGE_ID_WB_BYPASS_EN the same way the design does.

module tb_stage_id;

    localparam logic [31:0] I_ADDI_X1_5 = 32'h00500093;
    localparam logic [31:0] I_ADDI_X2_7 = 32'h00700113;
    localparam logic [31:0] I_SUB_3_1_2 = 32'h402081B3;
    localparam logic [31:0] I_ADD_4_3_3 = 32'h00318233;
    localparam logic [31:0] I_BEQ_M8    = 32'hFE208CE3;
    localparam logic [31:0] I_BRF3_010  = 32'hFE20ACE3;
    localparam logic [31:0] I_LW        = 32'h0000A283;
    localparam logic [31:0] I_LUI       = 32'h123452B7;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_instr;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_a, out_b, out_offset;
    logic [4:0]  out_rd;
    logic        out_rd_valid;
    logic [1:0]  out_unit;
    logic [3:0]  out_op;
    logic        illegal;
    logic [31:0] illegal_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rs1_data = (rs1_addr == 5'd0) ? 32'hDEADBEEF : (32'h1000 + {27'd0, rs1_addr});
    assign rs2_data = (rs2_addr == 5'd0) ? 32'hDEADBEEF : (32'h1000 + {27'd0, rs2_addr});

    stage_id #(.Width(32), .NumRegs(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rd(out_rd), .out_rd_valid(out_rd_valid),
        .out_a(out_a), .out_b(out_b), .out_offset(out_offset),
        .out_unit(out_unit), .out_op(out_op),
        .illegal(illegal), .illegal_pc(illegal_pc)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        in_valid = 1'b0; in_pc = '0; in_instr = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b0;
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Presents one fetch word until accepted; returns at posedge+1 after the fire.
    task automatic send(input logic [31:0] pc, input logic [31:0] instr);
        bit accepted = 0;
        in_valid = 1'b1; in_pc = pc; in_instr = instr;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) accepted = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!accepted) begin errors++; $display("FAIL send_accept pc=%h: in_ready never 1 within 20 cycles", pc); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", illegal); end
        checks++; if (illegal_pc !== 32'h0) begin errors++; $display("FAIL rst_illegal_pc: got %h want 0", illegal_pc); end
        checks++; if ({out_pc, out_rd, out_rd_valid, out_a, out_b, out_offset, out_unit, out_op} !== '0) begin errors++; $display("FAIL rst_payload: pc=%h a=%h b=%h nonzero", out_pc, out_a, out_b); end
        checks++; if (dut.busy_q !== 32'h0) begin errors++; $display("FAIL rst_busy: got %h want 0", dut.busy_q); end
        @(posedge clk); #1 rst = 1'b1;

        // Build up state: busy[1] set, second word held in the output register
        out_ready = 1'b1;
        send(32'h0, I_ADDI_X1_5);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h4, I_ADDI_X2_7);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_out_valid: got %b want 1", out_valid); end
        checks++; if (dut.busy_q !== 32'h2) begin errors++; $display("FAIL pre_rst_busy: got %h want 00000002", dut.busy_q); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_out_valid: got %b want 0", out_valid); end
        checks++; if (dut.busy_q !== 32'h0) begin errors++; $display("FAIL async_rst_busy: got %h want 0", dut.busy_q); end
        @(posedge clk); #1 rst = 1'b1;

        send(32'h8, I_ADDI_X1_5);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        checks++; if (out_unit !== 2'd0) begin errors++; $display("FAIL addi_unit: got %0d want 0", out_unit); end
        checks++; if (out_op !== 4'b0000) begin errors++; $display("FAIL addi_op: got %b want 0000", out_op); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL addi_a: got %h want 0", out_a); end
        checks++; if (out_b !== 32'h5) begin errors++; $display("FAIL addi_b: got %h want 5", out_b); end
        checks++; if (out_rd !== 5'd1 || out_rd_valid !== 1'b1) begin errors++; $display("FAIL addi_rd: got rd=%0d v=%b want rd=1 v=1", out_rd, out_rd_valid); end
        checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL addi_pc: got %h want 8", out_pc); end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        out_ready = 1'b1;
        send(32'h10, I_SUB_3_1_2);
        checks++; if (out_op !== 4'b1000) begin errors++; $display("FAIL sub_op: got %b want 1000", out_op); end
        checks++; if (out_a !== 32'h1001 || out_b !== 32'h1002) begin errors++; $display("FAIL sub_ab: got a=%h b=%h want 1001/1002", out_a, out_b); end
        in_valid = 1'b1; in_pc = 32'h14; in_instr = I_ADD_4_3_3;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_pending_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_busy_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_drained: got %b want 0", out_valid); end
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hCAFE0001;
        @(negedge clk);
`ifdef STAGE_ID_WB_BYPASS_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        wb_valid = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b want 1", out_valid); end
        checks++; if (out_a !== 32'hCAFE0001 || out_b !== 32'hCAFE0001) begin errors++; $display("FAIL bypass_ab: got a=%h b=%h want cafe0001", out_a, out_b); end
        checks++; if (out_rd !== 5'd4) begin errors++; $display("FAIL bypass_rd: got %0d want 4", out_rd); end
        checks++; if (dut.busy_q[3] !== 1'b0) begin errors++; $display("FAIL bypass_busy3: got %b want 0", dut.busy_q[3]); end
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nobypass_wait: got %b want 0", out_valid); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nobypass_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nobypass_valid: got %b want 1", out_valid); end
        checks++; if (out_a !== 32'h1003 || out_b !== 32'h1003) begin errors++; $display("FAIL nobypass_ab: got a=%h b=%h want 1003", out_a, out_b); end
        checks++; if (out_rd !== 5'd4) begin errors++; $display("FAIL nobypass_rd: got %0d want 4", out_rd); end
`endif
    endtask

    task automatic test_branch();
        do_reset();
        send(32'h100, I_BEQ_M8);
        checks++; if (out_op !== 4'b1000 || out_unit !== 2'd1) begin errors++; $display("FAIL beq_op_unit: got op=%b unit=%0d want 1000/1", out_op, out_unit); end
        checks++; if (out_offset !== 32'hFFFFFFF8) begin errors++; $display("FAIL beq_offset: got %h want fffffff8", out_offset); end
        checks++; if (out_rd_valid !== 1'b0) begin errors++; $display("FAIL beq_rd_valid: got %b want 0", out_rd_valid); end
        checks++; if (out_a !== 32'h1001 || out_b !== 32'h1002 || out_pc !== 32'h100) begin errors++; $display("FAIL beq_ab_pc: got a=%h b=%h pc=%h", out_a, out_b, out_pc); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL beq_drain: got %b want 0", out_valid); end
        checks++; if (dut.busy_q !== 32'h0) begin errors++; $display("FAIL beq_busy: got %h want 0", dut.busy_q); end
    endtask

    task automatic test_backpressure();
        do_reset();
        send(32'h20, I_ADDI_X1_5);
        in_valid = 1'b1; in_pc = 32'h24; in_instr = I_ADDI_X2_7;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c%0d: got %b want 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_b !== 32'h5) begin errors++; $display("FAIL bp_hold c%0d: v=%b pc=%h b=%h want 1/20/5", c, out_valid, out_pc, out_b); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h24 || out_b !== 32'h7 || out_rd !== 5'd2) begin errors++; $display("FAIL bp_next: v=%b pc=%h b=%h rd=%0d want 1/24/7/2", out_valid, out_pc, out_b, out_rd); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        send(32'h30, I_ADDI_X1_5);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h34, I_ADDI_X2_7);
        in_valid = 1'b1; in_pc = 32'h38; in_instr = I_LUI; flush = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (dut.busy_q !== 32'h2) begin errors++; $display("FAIL flush_busy: got %h want 00000002", dut.busy_q); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_load: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        do_reset();
        send(32'h40, I_LW);
        checks++; if (illegal !== 1'b1 || illegal_pc !== 32'h40) begin errors++; $display("FAIL load_illegal: got %b pc=%h want 1/40", illegal, illegal_pc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_out_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (illegal !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL load_pulse_end: illegal=%b v=%b want 0/0", illegal, out_valid); end
        send(32'h44, I_BRF3_010);
        checks++; if (illegal !== 1'b1 || illegal_pc !== 32'h44 || out_valid !== 1'b0) begin errors++; $display("FAIL br010_illegal: got %b pc=%h v=%b want 1/44/0", illegal, illegal_pc, out_valid); end
    endtask

    typedef struct {
        logic [31:0] pc, instr, a, b;
        logic [1:0]  unit;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rdv;
    } vec_t;

    task automatic test_decode();
        vec_t v[5];
        v[0] = '{32'h180, I_LUI,        32'h0,    32'h12345000, 2'd0, 4'b0000, 5'd5, 1'b1};
        v[1] = '{32'h200, 32'h00001317, 32'h200,  32'h1000,     2'd0, 4'b0000, 5'd6, 1'b1};
        v[2] = '{32'h300, 32'h010000EF, 32'h300,  32'h10,       2'd1, 4'b0000, 5'd1, 1'b1};
        v[3] = '{32'h310, 32'h4030D393, 32'h1001, 32'h403,      2'd0, 4'b1101, 5'd7, 1'b1};
        v[4] = '{32'h320, 32'h00008067, 32'h1001, 32'h0,        2'd1, 4'b0000, 5'd0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            do_reset();
            send(v[k].pc, v[k].instr);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== v[k].pc || out_unit !== v[k].unit || out_op !== v[k].op ||
                out_a !== v[k].a || out_b !== v[k].b || out_rd !== v[k].rd || out_rd_valid !== v[k].rdv) begin
                errors++;
                $display("FAIL decode_%0d: got v=%b pc=%h unit=%0d op=%b a=%h b=%h rd=%0d rdv=%b want pc=%h unit=%0d op=%b a=%h b=%h rd=%0d rdv=%b",
                         k, out_valid, out_pc, out_unit, out_op, out_a, out_b, out_rd, out_rd_valid,
                         v[k].pc, v[k].unit, v[k].op, v[k].a, v[k].b, v[k].rd, v[k].rdv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_raw_hazard();
        test_branch();
        test_backpressure();
        test_flush();
        test_illegal();
        test_decode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
